// File: rtl/mlp_pkg.sv
// Shared constants, state encoding and fixed-point helpers for the
// 784-32-10 quantized MLP inference sequencer.
package mlp_pkg;

  localparam int N_IN  = 784;
  localparam int N_HID = 32;
  localparam int N_OUT = 10;
  localparam int ACC_W = 32;
  localparam int SHIFT = 7;

  localparam int ROW_W = 10;
  localparam int CLS_W = 4;
  localparam int HID_W = $clog2(N_HID);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_L1     = 3'd1;
  localparam logic [2:0] S_BIAS1  = 3'd2;
  localparam logic [2:0] S_L2     = 3'd3;
  localparam logic [2:0] S_BIAS2  = 3'd4;
  localparam logic [2:0] S_ARGMAX = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [1:0] LSEL_IDLE = 2'd0;
  localparam logic [1:0] LSEL_L1   = 2'd1;
  localparam logic [1:0] LSEL_L2   = 2'd2;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic [ROW_W-1:0]        row_t;

  localparam row_t             L1_LAST_ROW = row_t'(N_IN - 1);
  localparam row_t             L2_LAST_ROW = row_t'(N_HID - 1);
  localparam logic [CLS_W-1:0] LAST_CLASS  = CLS_W'(N_OUT - 1);

  function automatic acc_t sext8(input logic [7:0] v);
    return {{(ACC_W-8){v[7]}}, v};
  endfunction

  // Unsigned 8-bit activation times signed int8 weight; the 17-bit signed
  // product cannot overflow (255 * -128 is the extreme) before sign extension.
  function automatic acc_t mac_term(input logic [7:0] act, input logic [7:0] w);
    logic signed [16:0] a17;
    logic signed [16:0] w17;
    logic signed [16:0] p;
    a17 = {9'd0, act};
    w17 = {{9{w[7]}}, w};
    p   = a17 * w17;
    return {{(ACC_W-17){p[16]}}, p};
  endfunction

endpackage

// File: rtl/mlp_requant.sv
// Hidden-layer requantization: arithmetic shift down, then ReLU and
// saturation into the 0..127 activation range.
module mlp_requant
  import mlp_pkg::*;
(
  input  logic signed [ACC_W-1:0] value,
  output logic        [7:0]       hidden
);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = value >>> SHIFT;
    if (shifted < 0) begin
      hidden = 8'd0;
    end else if (shifted > 127) begin
      hidden = 8'd127;
    end else begin
      hidden = shifted[7:0];
    end
  end

endmodule

// File: rtl/mlp_infer_seq.sv
// Sequencer for one 784-32-10 quantized MLP inference: streams pixels through
// layer 1, requantizes, runs layer 2 from the hidden values and reports argmax.
module mlp_infer_seq
  import mlp_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           pix_data,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic [1:0]           layer_sel,
  output logic [ROW_W-1:0]     row_idx,
  input  logic [8*N_HID-1:0]   w1_packed,
  input  logic [8*N_HID-1:0]   b1_packed,
  input  logic [8*N_OUT-1:0]   w2_packed,
  input  logic [8*N_OUT-1:0]   b2_packed,
  output logic                 busy,
  output logic                 done,
  output logic [CLS_W-1:0]     class_idx,
  output logic [ACC_W-1:0]     max_score
);

  logic [2:0]       state;
  acc_t             acc1 [N_HID];
  acc_t             acc2 [N_OUT];
  logic [7:0]       hid  [N_HID];

  acc_t             l1_term     [N_HID];
  acc_t             acc1_biased [N_HID];
  logic [7:0]       h_next      [N_HID];
  acc_t             l2_term     [N_OUT];
  logic [7:0]       hid_row;

  logic [CLS_W-1:0] scan_idx;
  logic [CLS_W-1:0] best_idx;
  logic [CLS_W-1:0] next_idx;
  acc_t             best_score;
  acc_t             next_best;
  acc_t             cand;
  logic             take;
  logic             beat;

  assign beat    = pix_valid && pix_ready;
  assign hid_row = hid[row_idx[HID_W-1:0]];

  always_comb begin
    for (int j = 0; j < N_HID; j++) begin
      l1_term[j]     = mac_term(pix_data, w1_packed[8*j +: 8]);
      acc1_biased[j] = acc1[j] + sext8(b1_packed[8*j +: 8]);
    end
    for (int k = 0; k < N_OUT; k++) begin
      l2_term[k] = mac_term(hid_row, w2_packed[8*k +: 8]);
    end
  end

  for (genvar g = 0; g < N_HID; g++) begin : g_requant
    mlp_requant u_requant (
      .value  (acc1_biased[g]),
      .hidden (h_next[g])
    );
  end

  // Running argmax; the first class always seeds the best, later ones must be strictly larger.
  always_comb begin
    cand      = acc2[scan_idx];
    take      = (scan_idx == '0) || (cand > best_score);
    next_best = take ? cand : best_score;
    next_idx  = take ? scan_idx : best_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      layer_sel  <= LSEL_IDLE;
      row_idx    <= '0;
      pix_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      scan_idx   <= '0;
      best_idx   <= '0;
      best_score <= '0;
      class_idx  <= '0;
      max_score  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        layer_sel <= LSEL_IDLE;
        row_idx   <= '0;
        pix_ready <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state     <= S_L1;
              layer_sel <= LSEL_L1;
              row_idx   <= '0;
              pix_ready <= 1'b1;
              busy      <= 1'b1;
            end
          end
          S_L1: begin
            if (beat) begin
              if (row_idx == L1_LAST_ROW) begin
                row_idx   <= '0;
                pix_ready <= 1'b0;
                state     <= S_BIAS1;
              end else begin
                row_idx <= row_idx + 1'b1;
              end
            end
          end
          S_BIAS1: begin
            layer_sel <= LSEL_L2;
            row_idx   <= '0;
            state     <= S_L2;
          end
          S_L2: begin
            if (row_idx == L2_LAST_ROW) begin
              row_idx <= '0;
              state   <= S_BIAS2;
            end else begin
              row_idx <= row_idx + 1'b1;
            end
          end
          S_BIAS2: begin
            layer_sel <= LSEL_IDLE;
            scan_idx  <= '0;
            state     <= S_ARGMAX;
          end
          S_ARGMAX: begin
            best_score <= next_best;
            best_idx   <= next_idx;
            if (scan_idx == LAST_CLASS) begin
              class_idx <= next_idx;
              max_score <= next_best;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              scan_idx <= scan_idx + 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Datapath: accumulators only move in their own layer; an abort freezes them until the next start clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < N_HID; j++) begin
        acc1[j] <= '0;
        hid[j]  <= '0;
      end
      for (int k = 0; k < N_OUT; k++) begin
        acc2[k] <= '0;
      end
    end else if (!abort) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int j = 0; j < N_HID; j++) begin
              acc1[j] <= '0;
            end
            for (int k = 0; k < N_OUT; k++) begin
              acc2[k] <= '0;
            end
          end
        end
        S_L1: begin
          if (beat) begin
            for (int j = 0; j < N_HID; j++) begin
              acc1[j] <= acc1[j] + l1_term[j];
            end
          end
        end
        S_BIAS1: begin
          for (int j = 0; j < N_HID; j++) begin
            acc1[j] <= acc1_biased[j];
            hid[j]  <= h_next[j];
          end
        end
        S_L2: begin
          for (int k = 0; k < N_OUT; k++) begin
            acc2[k] <= acc2[k] + l2_term[k];
          end
        end
        S_BIAS2: begin
          for (int k = 0; k < N_OUT; k++) begin
            acc2[k] <= acc2[k] + sext8(b2_packed[8*k +: 8]);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_infer_seq.sv
// Self-checking bench for mlp_infer_seq: a bench-side weight memory, a plain
// integer model of the network, and a per-cycle monitor of the reported result.
module tb_mlp_infer_seq;
  import mlp_pkg::*;

  logic               clk;
  logic               rst;
  logic               start;
  logic               abort;
  logic [7:0]         pix_data;
  logic               pix_valid;
  logic               pix_ready;
  logic [1:0]         layer_sel;
  logic [ROW_W-1:0]   row_idx;
  logic [8*N_HID-1:0] w1_packed;
  logic [8*N_HID-1:0] b1_packed;
  logic [8*N_OUT-1:0] w2_packed;
  logic [8*N_OUT-1:0] b2_packed;
  logic               busy;
  logic               done;
  logic [CLS_W-1:0]   class_idx;
  logic [ACC_W-1:0]   max_score;

  int img [N_IN];
  int w1m [N_IN][N_HID];
  int b1m [N_HID];
  int w2m [N_HID][N_OUT];
  int b2m [N_OUT];

  int errors;
  int checks;
  bit mon_en;
  bit exp_valid;
  int exp_class;
  int exp_score;
  int held_class;
  int held_score;

  mlp_infer_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .layer_sel (layer_sel),
    .row_idx   (row_idx),
    .w1_packed (w1_packed),
    .b1_packed (b1_packed),
    .w2_packed (w2_packed),
    .b2_packed (b2_packed),
    .busy      (busy),
    .done      (done),
    .class_idx (class_idx),
    .max_score (max_score)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Zero-latency weight/bias memory addressed by the sequencer's row index.
  always_comb begin
    int r1;
    int r2;
    r1 = (int'(row_idx) < N_IN)  ? int'(row_idx) : 0;
    r2 = (int'(row_idx) < N_HID) ? int'(row_idx) : 0;
    w1_packed = '0;
    b1_packed = '0;
    w2_packed = '0;
    b2_packed = '0;
    for (int j = 0; j < N_HID; j++) begin
      w1_packed[8*j +: 8] = 8'(w1m[r1][j]);
      b1_packed[8*j +: 8] = 8'(b1m[j]);
    end
    for (int k = 0; k < N_OUT; k++) begin
      w2_packed[8*k +: 8] = 8'(w2m[r2][k]);
      b2_packed[8*k +: 8] = 8'(b2m[k]);
    end
  end

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Straight matrix arithmetic: h = relu/saturate(floor((W1*x + b1)/128)), y = W2*h + b2.
  task automatic compute_model(output int cls, output int score);
    int acc1;
    int h [N_HID];
    int y [N_OUT];
    for (int j = 0; j < N_HID; j++) begin
      acc1 = b1m[j];
      for (int r = 0; r < N_IN; r++) acc1 += img[r] * w1m[r][j];
      if (acc1 < 0) h[j] = 0;
      else if (acc1 / 128 > 127) h[j] = 127;
      else h[j] = acc1 / 128;
    end
    for (int k = 0; k < N_OUT; k++) begin
      y[k] = b2m[k];
      for (int i = 0; i < N_HID; i++) y[k] += h[i] * w2m[i][k];
    end
    cls = 0;
    score = y[0];
    for (int k = 1; k < N_OUT; k++) begin
      if (y[k] > score) begin
        cls = k;
        score = y[k];
      end
    end
  endtask

  function automatic int rnd8();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic fill_uniform(input int pix, input int w1, input int b1, input int w2, input int b2);
    for (int r = 0; r < N_IN; r++) begin
      img[r] = pix;
      for (int j = 0; j < N_HID; j++) w1m[r][j] = w1;
    end
    for (int j = 0; j < N_HID; j++) begin
      b1m[j] = b1;
      for (int k = 0; k < N_OUT; k++) w2m[j][k] = w2;
    end
    for (int k = 0; k < N_OUT; k++) b2m[k] = b2;
  endtask

  task automatic fill_random();
    for (int r = 0; r < N_IN; r++) begin
      img[r] = int'($urandom_range(255));
      for (int j = 0; j < N_HID; j++) w1m[r][j] = int'($urandom_range(8)) - 4;
    end
    for (int j = 0; j < N_HID; j++) begin
      b1m[j] = rnd8();
      for (int k = 0; k < N_OUT; k++) w2m[j][k] = rnd8();
    end
    for (int k = 0; k < N_OUT; k++) b2m[k] = rnd8();
  endtask

  // One inference: optional alternating-valid backpressure, optional abort at a given L1 row.
  task automatic apply_stimulus(input bit stall, input int abort_row, input int exp_cycle);
    int cyc;
    int nbeat;
    int done_cyc;
    bit aborted;
    int m_cls;
    int m_score;
    compute_model(m_cls, m_score);
    exp_class = m_cls;
    exp_score = m_score;
    exp_valid = (abort_row < 0);
    nbeat = 0;
    done_cyc = -1;
    aborted = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    pix_valid = !stall;
    pix_data = 8'(img[0]);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    pix_valid = !stall;
    while (cyc < 2000) begin
      @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (pix_valid && pix_ready) nbeat++;
      if (abort_row >= 0 && layer_sel == LSEL_L1 && int'(row_idx) == abort_row) begin
        abort = 1'b1;
        aborted = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (aborted) begin
        abort = 1'b0;
        pix_valid = 1'b0;
        check_output("abort_busy", longint'(busy), 0);
        check_output("abort_layer_sel", longint'(layer_sel), 0);
        check_output("abort_row_idx", longint'(row_idx), 0);
        check_output("abort_pix_ready", longint'(pix_ready), 0);
        check_output("abort_done", longint'(done), 0);
        repeat (900) @(negedge clk);
        check_output("abort_stays_idle_busy", longint'(busy), 0);
        return;
      end
      pix_valid = stall ? (cyc % 2 == 0) : 1'b1;
      pix_data = 8'(img[(nbeat < N_IN) ? nbeat : 0]);
    end
    check_output("done_cycle", longint'(done_cyc), longint'(exp_cycle));
    check_output("beats_accepted", longint'(nbeat), longint'(N_IN));
    check_output("busy_low_at_done", longint'(busy), 0);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    check_output("done_single_pulse", longint'(done), 0);
  endtask

  task automatic reset_mid_l2();
    bit seen;
    seen = 1'b0;
    exp_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    pix_valid = 1'b1;
    pix_data = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(negedge clk);
      if (layer_sel == LSEL_L2) seen = 1'b1;
    end
    check_output("reached_l2", longint'(seen), 1);
    #2;
    rst = 1'b0;
    held_class = 0;
    held_score = 0;
    #1;
    check_output("arst_layer_sel", longint'(layer_sel), 0);
    check_output("arst_row_idx", longint'(row_idx), 0);
    check_output("arst_busy", longint'(busy), 0);
    check_output("arst_pix_ready", longint'(pix_ready), 0);
    check_output("arst_class_idx", longint'(class_idx), 0);
    check_output("arst_max_score", longint'($signed(max_score)), 0);
    pix_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Every cycle: a done pulse must carry the model's result, otherwise the last result is held.
  always @(negedge clk) begin
    if (rst && mon_en) begin
      if (done) begin
        check_output("done_expected", longint'(exp_valid), 1);
        check_output("class_idx", longint'(class_idx), longint'(exp_class));
        check_output("max_score", longint'($signed(max_score)), longint'(exp_score));
        held_class = exp_class;
        held_score = exp_score;
        exp_valid = 1'b0;
      end else begin
        check_output("held_class", longint'(class_idx), longint'(held_class));
        check_output("held_score", longint'($signed(max_score)), longint'(held_score));
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    mon_en = 1'b0;
    exp_valid = 1'b0;
    exp_class = 0;
    exp_score = 0;
    held_class = 0;
    held_score = 0;
    rst = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    pix_valid = 1'b0;
    pix_data = 8'd0;
    fill_uniform(0, 0, 0, 0, 0);
    #3;
    check_output("reset_layer_sel", longint'(layer_sel), 0);
    check_output("reset_row_idx", longint'(row_idx), 0);
    check_output("reset_pix_ready", longint'(pix_ready), 0);
    check_output("reset_busy", longint'(busy), 0);
    check_output("reset_done", longint'(done), 0);
    check_output("reset_class_idx", longint'(class_idx), 0);
    check_output("reset_max_score", longint'($signed(max_score)), 0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    $display("[TB] zero network, b2[3]=5");
    fill_uniform(0, 0, 0, 0, 0);
    b2m[3] = 5;
    apply_stimulus(1'b0, -1, 829);
    check_output("zero_class_lit", longint'(class_idx), 3);
    check_output("zero_score_lit", longint'($signed(max_score)), 5);

    $display("[TB] requantization path, h=6 into lane 7");
    fill_uniform(1, 1, 0, 0, 0);
    for (int i = 0; i < N_HID; i++) w2m[i][7] = 1;
    apply_stimulus(1'b0, -1, 829);
    check_output("requant_class_lit", longint'(class_idx), 7);
    check_output("requant_score_lit", longint'($signed(max_score)), 192);

    $display("[TB] saturation, h=127 on every lane");
    fill_random();
    fill_uniform(255, 127, 0, 0, 0);
    for (int j = 0; j < N_HID; j++) begin
      b1m[j] = rnd8();
      for (int k = 0; k < N_OUT; k++) w2m[j][k] = rnd8();
    end
    for (int k = 0; k < N_OUT; k++) b2m[k] = rnd8();
    apply_stimulus(1'b0, -1, 829);

    $display("[TB] ReLU, negative layer-1 sums");
    for (int r = 0; r < N_IN; r++)
      for (int j = 0; j < N_HID; j++) w1m[r][j] = -1;
    for (int k = 0; k < N_OUT; k++) b2m[k] = 3 * k - 20;
    b2m[6] = 100;
    apply_stimulus(1'b0, -1, 829);
    check_output("relu_class_lit", longint'(class_idx), 6);
    check_output("relu_score_lit", longint'($signed(max_score)), 100);

    $display("[TB] tie on every class");
    for (int k = 0; k < N_OUT; k++) b2m[k] = 3;
    apply_stimulus(1'b0, -1, 829);
    check_output("tie_class_lit", longint'(class_idx), 0);
    check_output("tie_score_lit", longint'($signed(max_score)), 3);

    $display("[TB] random networks, continuous and stalled");
    for (int n = 0; n < 2; n++) begin
      fill_random();
      apply_stimulus(1'b0, -1, 829);
    end
    apply_stimulus(1'b1, -1, 1613);

    $display("[TB] abort at row 400, then a fresh run");
    fill_random();
    apply_stimulus(1'b0, 400, 0);
    apply_stimulus(1'b0, -1, 829);

    $display("[TB] asynchronous reset during layer 2, then a fresh run");
    reset_mid_l2();
    fill_random();
    apply_stimulus(1'b0, -1, 829);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mlp_infer_seq.md
Name: mlp_infer_seq

Overview:
- Sequencer for one 784-32-10 quantized MLP inference.
- Drives layer_sel/row_idx of the weight/bias memory controller and consumes its packed combinational read data in the same cycle.
- Accepts an 8-bit pixel stream and accumulates both layers; applies bias, ReLU and requantization; reports the argmax class.
- Sits between the image input front end and the result/UART reporting logic.

Parameters:
- N_IN, 784, input rows (pixels)
- N_HID, 32, hidden neurons
- N_OUT, 10, output classes
- ACC_W, 32, signed accumulator width
- SHIFT, 7, arithmetic right shift applied in hidden-layer requantization

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin inference; sampled only in IDLE
- abort  in  1  synchronous abort, returns to IDLE
- pix_data  in  8  unsigned pixel
- pix_valid  in  1  pixel valid
- pix_ready  out  1  pixel accepted when valid&&ready
- layer_sel  out  2  to memory controller: 0 idle, 1 layer1, 2 layer2
- row_idx  out  10  to memory controller: current row
- w1_packed  in  256  32 signed int8 weights, lane j at [8j+:8]
- b1_packed  in  256  32 signed int8 biases
- w2_packed  in  80  10 signed int8 weights
- b2_packed  in  80  10 signed int8 biases
- busy  out  1  high from cycle after start through the ARGMAX state
- done  out  1  one-cycle pulse, result valid
- class_idx  out  4  winning class, held until next done
- max_score  out  ACC_W  winning logit, held until next done

Behaviour:
- Reset (rst=0, async): state IDLE; layer_sel=0, row_idx=0, pix_ready=0, busy=0, done=0, class_idx=0, max_score=0; all accumulators cleared.
- All outputs are registered. Memory read data is treated as valid in the same cycle that layer_sel/row_idx are presented (zero-latency read).
- IDLE: start=1 clears acc1[0..31] and acc2[0..9], sets row_idx=0 and layer_sel=1, and moves to L1. start is ignored outside IDLE.
- L1: pix_ready=1. On each beat, for every j, acc1[j] += zext9(pix_data) * w1[j], using a signed 17-bit product sign-extended to ACC_W. row_idx then increments.
  - On the beat with row_idx=N_IN-1: pix_ready drops, row_idx=0, move to BIAS1.
  - pix_valid low stalls L1 with no state change. Beats presented outside L1 are not accepted.
- BIAS1 (1 cycle, layer_sel=1): acc1[j] += sext(b1[j]).
  - Hidden value h[j] = clamp(acc1[j] >>> SHIFT, 0, 127), stored as 8-bit (ReLU plus saturation).
  - Set layer_sel=2 and row_idx=0, then go to L2.
- L2: one row per cycle, no stalls. For every k, acc2[k] += h[row_idx] * w2[k], using signed products. After row N_HID-1, go to BIAS2.
- BIAS2 (1 cycle): acc2[k] += sext(b2[k]). layer_sel=0, go to ARGMAX.
- ARGMAX: scans k=0..N_OUT-1, one class per cycle, using strict greater-than, so ties resolve to the lowest index. After k=N_OUT-1, latch class_idx and max_score and go to DONE.
- DONE (1 cycle): done=1, busy=0, then IDLE.
- Latency with continuous pix_valid: start sampled in cycle 0, done=1 in cycle 829 (784 L1 + 1 + 32 + 1 + 10 + 1). Each L1 stall cycle adds exactly one cycle.
- abort=1 in any non-IDLE state: next cycle is IDLE with layer_sel=0, row_idx=0, pix_ready=0, busy=0, and no done. class_idx/max_score keep their previous values. abort has priority over start in IDLE.
- Width rule: the worst-case L1 sum 784*255*128 fits in 27 bits, so there is no overflow at ACC_W=32.

Decomposition:
- Shared package mlp_pkg holds N_IN, N_HID, N_OUT, ACC_W, SHIFT, and the state encoding (IDLE, L1, BIAS1, L2, BIAS2, ARGMAX, DONE).
- One natural sub-module: mlp_requant (combinational clamp(x>>>SHIFT, 0, 127)), instantiated 32 times.

Test Plan:
- Zero case: all pixels 0, all weights 0, b2[3]=5, others 0 -> class_idx=3, max_score=5, done exactly in cycle 829.
- Requant path: pixels=1, w1 all 1, b1=0 -> acc1=784 and h=6. Then w2 rows with lane 7 = 1 and others 0, b2=0 -> class_idx=7, max_score=192.
- Saturation/ReLU: pixels=255, w1=127 -> h=127 for all lanes. Repeat with w1=-1 -> h=0 for all lanes and max_score=b2 maximum. Ties with all b2=3 -> class_idx=0.
- Backpressure: pix_valid alternating 0/1 starting low -> exactly 784 beats accepted, done in cycle 829+784=1613, result identical to the unstalled run.
- Abort at row_idx=400 -> next cycle busy=0, layer_sel=0, row_idx=0, no done pulse, prior class_idx held. A new start then completes correctly.
- Async reset asserted mid-L2 -> all outputs reset immediately without waiting for clk. start issued after release completes normally.
